// File: rtl/seq_skip_sub_16bit.sv
// Multi-cycle subtractor D = A - B - bin, evaluated one chunk per clock (LSB first)
// with 4-bit carry-skip groups inside each chunk and a registered carry between chunks.
module seq_skip_sub_16bit #(
    parameter int unsigned width = 16,
    parameter int unsigned chunk = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width:1]   A,
    input  logic [width:1]   B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width:1]   D,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned n_chunks = width / chunk;
    localparam int unsigned n_groups = chunk / 4;
    localparam int unsigned kw       = (n_chunks > 1) ? $clog2(n_chunks) : 1;
    localparam logic [kw-1:0] k_last = kw'(n_chunks - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [width:1]     a_q;
    logic [width:1]     b_q;
    logic               c_q;
    logic [kw-1:0]      k_q;
    logic               idle_q;

    logic [chunk-1:0]   a_chunk;
    logic [chunk-1:0]   nb_chunk;
    logic [chunk-1:0]   sum_chunk;
    logic               c_out;
    logic [width:1]     d_next;

    // Held low during reset so no operand is accepted while rst is asserted.
    assign in_ready = idle_q & ~rst;

    // Select the operand chunk addressed by k; B is inverted for the subtract.
    always_comb begin
        a_chunk  = '0;
        nb_chunk = '0;
        for (int unsigned i = 0; i < n_chunks; i++) begin
            if (k_q == kw'(i)) begin
                a_chunk  = a_q[i*chunk+1 +: chunk];
                nb_chunk = ~b_q[i*chunk+1 +: chunk];
            end
        end
    end

    // Carry-skip chunk adder: a group whose bits all propagate passes its carry-in straight through.
    always_comb begin : skip_chain
        logic grp_c;
        logic rip_c;
        logic grp_p;
        logic p;
        logic g;
        sum_chunk = '0;
        grp_c     = c_q;
        rip_c     = 1'b0;
        grp_p     = 1'b0;
        p         = 1'b0;
        g         = 1'b0;
        for (int unsigned gi = 0; gi < n_groups; gi++) begin
            rip_c = grp_c;
            grp_p = 1'b1;
            for (int unsigned bi = 0; bi < 4; bi++) begin
                p = a_chunk[gi*4+bi] ^ nb_chunk[gi*4+bi];
                g = a_chunk[gi*4+bi] & nb_chunk[gi*4+bi];
                sum_chunk[gi*4+bi] = p ^ rip_c;
                rip_c = g | (p & rip_c);
                grp_p = grp_p & p;
            end
            grp_c = grp_p ? grp_c : rip_c;
        end
        c_out = grp_c;
    end

    // Difference with the current chunk merged in; used for the final flags.
    always_comb begin
        d_next = D;
        for (int unsigned i = 0; i < n_chunks; i++) begin
            if (k_q == kw'(i)) begin
                d_next[i*chunk+1 +: chunk] = sum_chunk;
            end
        end
    end

    // Control FSM with registered results and handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idle_q    <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= 1'b0;
            k_q       <= '0;
            D         <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= A;
                        b_q    <= B;
                        c_q    <= ~bin;
                        k_q    <= '0;
                        idle_q <= 1'b0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    D   <= d_next;
                    c_q <= c_out;
                    k_q <= k_q + kw'(1);
                    if (k_q == k_last) begin
                        bout      <= ~c_out;
                        ovf       <= (a_q[width] != b_q[width]) && (d_next[width] != a_q[width]);
                        zero      <= (d_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idle_q    <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    idle_q    <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_skip_sub_16bit.sv
// Bench for seq_skip_sub_16bit: directed vector table, handshake corner sequences,
// and randomized back-to-back traffic checked against an arithmetic reference.
module tb_seq_skip_sub_16bit;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [16:1]   A;
    logic [16:1]   B;
    logic          bin;
    logic          out_valid;
    logic          out_ready;
    logic [16:1]   D;
    logic          bout;
    logic          ovf;
    logic          zero;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t tbl[10];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    seq_skip_sub_16bit #(.width(16), .chunk(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain unsigned and signed arithmetic on the operands.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bi,
                                  output logic [15:0] d, output logic bo, output logic ov,
                                  output logic z);
        logic [16:0] diff;
        int          sd;
        diff = {1'b0, a} - {1'b0, b} - 17'(bi);
        d    = diff[15:0];
        bo   = diff[16];
        sd   = int'($signed(a)) - int'($signed(b)) - int'(bi);
        ov   = (sd > 32767) || (sd < -32768);
        z    = (d == 16'h0000);
    endfunction

    // Accept one operation, wait for its result, record latency, then consume it.
    task automatic do_op(input vec_t v, output logic [15:0] d, output logic bo, output logic ov,
                         output logic z, output int lat);
        int guard;
        A        = v.a;
        B        = v.b;
        bin      = v.bin;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("accept ready", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
        A        = 16'($urandom);
        B        = 16'($urandom);
        bin      = 1'($urandom);
        lat      = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        d         = D;
        bo        = bout;
        ov        = ovf;
        z         = zero;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
        int          lat;
        int          guard;

        tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        bin       = 1'b0;
        tick();
        tick();
        check("reset in_ready", 32'(in_ready), 32'(0));
        check("reset out_valid", 32'(out_valid), 32'(0));
        check("reset D", 32'(D), 32'(0));
        check("reset bout", 32'(bout), 32'(0));
        check("reset ovf", 32'(ovf), 32'(0));
        check("reset zero", 32'(zero), 32'(0));
        rst = 1'b0;
        #1;
        check("in_ready after reset", 32'(in_ready), 32'(1));

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i], d, bo, ov, z, lat);
            check($sformatf("vec%0d D", i), 32'(d), 32'(tbl[i].d));
            check($sformatf("vec%0d bout", i), 32'(bo), 32'(tbl[i].bout));
            check($sformatf("vec%0d ovf", i), 32'(ov), 32'(tbl[i].ovf));
            check($sformatf("vec%0d zero", i), 32'(z), 32'(tbl[i].zero));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(2));
            check($sformatf("vec%0d out_valid drop", i), 32'(out_valid), 32'(0));
            check($sformatf("vec%0d in_ready back", i), 32'(in_ready), 32'(1));
        end

        // Back-pressure: result held while inputs churn.
        A = 16'h1234; B = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        check("bp out_valid", 32'(out_valid), 32'(1));
        for (int i = 0; i < 5; i++) begin
            A        = 16'($urandom);
            B        = 16'($urandom);
            bin      = 1'($urandom);
            in_valid = 1'($urandom);
            tick();
            check("bp D held", 32'(D), 32'(16'h0123));
            check("bp bout held", 32'(bout), 32'(0));
            check("bp out_valid held", 32'(out_valid), 32'(1));
            check("bp in_ready low", 32'(in_ready), 32'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp released", 32'(out_valid), 32'(0));
        check("bp idle", 32'(in_ready), 32'(1));

        // Reset in the middle of CALC abandons the operation.
        A = 16'hFFFF; B = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst calc out_valid", 32'(out_valid), 32'(0));
        check("rst calc D", 32'(D), 32'(0));
        check("rst calc in_ready", 32'(in_ready), 32'(0));
        rst = 1'b0;
        #1;
        check("rst calc in_ready after", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst calc no stale", 32'(out_valid), 32'(0));
        end
        out_ready = 1'b0;

        // Reset while a result waits in DONE.
        A = 16'h4000; B = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        check("rst done reached", 32'(out_valid), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst done out_valid", 32'(out_valid), 32'(0));
        check("rst done D", 32'(D), 32'(0));
        check("rst done in_ready", 32'(in_ready), 32'(1));

        // Randomized traffic with gaps on both handshakes.
        fork
            begin : driver
                vec_t v;
                logic accepted;
                int   g;
                for (int i = 0; i < 2000; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        in_valid = 1'b0;
                        A = 16'($urandom);
                        tick();
                    end
                    v.a   = 16'($urandom);
                    v.b   = 16'($urandom);
                    v.bin = 1'($urandom);
                    model(v.a, v.b, v.bin, v.d, v.bout, v.ovf, v.zero);
                    A        = v.a;
                    B        = v.b;
                    bin      = v.bin;
                    in_valid = 1'b1;
                    accepted = 1'b0;
                    g        = 0;
                    while (!accepted && g < 100) begin
                        accepted = in_ready;
                        tick();
                        g++;
                    end
                    in_valid = 1'b0;
                    if (!accepted) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL rand accept: op %0d not accepted within 100 cycles", i);
                        break;
                    end
                    exp_q.push_back(v);
                end
            end
            begin : monitor
                vec_t e;
                int   got;
                int   cyc;
                got = 0;
                cyc = 0;
                while (got < 2000 && cyc < 60000) begin
                    tick();
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL rand extra: result %0h with no pending op", D);
                        end else begin
                            e = exp_q.pop_front();
                            check("rand D", 32'(D), 32'(e.d));
                            check("rand bout", 32'(bout), 32'(e.bout));
                            check("rand ovf", 32'(ovf), 32'(e.ovf));
                            check("rand zero", 32'(zero), 32'(e.zero));
                        end
                        got++;
                    end
                    cyc++;
                end
                out_ready = 1'b0;
                check("rand results received", 32'(got), 32'(2000));
            end
        join

        check("rand queue drained", 32'(exp_q.size()), 32'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rand no extra result", 32'(out_valid), 32'(0));
        end
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_skip_sub_16bit.md
Name: seq_skip_sub_16bit

Overview:
Multi-cycle 16-bit subtractor: D = A - B - bin, computed as A + ~B + ~bin.
Processes one chunk per clock, LSB chunk first, with a registered borrow chained between chunks.
Each chunk uses 4-bit carry-skip groups.
Sits beside the combinational carry-skip adders as the area-lean subtract/compare unit, with valid/ready handshakes on both sides.

Parameters:
width, 16, operand/result width; bits indexed [width:1]; must be a multiple of chunk
chunk, 8, bits processed per cycle; must be a multiple of 4; N = width/chunk chunk cycles

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
A  input  width  minuend, indexed [width:1]
B  input  width  subtrahend, indexed [width:1]
bin  input  1  borrow in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
D  output  width  difference, indexed [width:1]
bout  output  1  borrow out; 1 when unsigned A < B + bin
ovf  output  1  two's-complement signed overflow of A - B - bin
zero  output  1  D == 0

Behaviour:
- Only one clock; rst is synchronous and active-high.
- Reset values:
  - state = IDLE; D = 0; bout = 0; ovf = 0; zero = 0; out_valid = 0.
  - in_ready = 0 while rst is high; in_ready = 1 in the first cycle after rst deasserts.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at an edge: latch A, B and bin; set carry register c = ~bin; set chunk index k = 0; go to CALC.
- CALC:
  - in_ready = 0.
  - Each edge: D chunk k = A chunk k + ~B chunk k + c.
  - Next c = chunk carry-out, generated by 4-bit carry-skip groups (group propagate = AND of bitwise A ^ ~B).
  - k increments each edge.
  - After chunk N-1 is written:
    - bout = ~c_final.
    - ovf = (A[width] != B[width]) && (D[width] != A[width]).
    - zero = (full D == 0).
    - Go to DONE.
- DONE:
  - out_valid = 1; D, bout, ovf and zero are held stable.
  - When out_valid && out_ready at an edge: go to IDLE; out_valid falls the next cycle.
- Latency:
  - Accept edge E0; chunk k is computed on edge E(k+1).
  - out_valid is high in the cycle after edge EN, i.e. 2 cycles after accept for the defaults.
  - Throughput: one operation per N+2 cycles minimum.
- Handshake rules:
  - in_ready is low in CALC and DONE; in_valid is ignored there.
  - Operands are sampled only at accept; later changes to A, B or bin have no effect.
  - out_ready may be held high permanently.
  - out_ready while out_valid is low has no effect.
- Boundary conditions:
  - Back-pressure: DONE is held indefinitely; outputs do not change.
  - Partial D: outputs may show partial D during CALC; consumers use D only when out_valid = 1.
  - bin = 1 with A == B: D = all ones, bout = 1.
  - Borrow ripples across the chunk boundary only through register c, never combinationally.
  - Reset mid-CALC or mid-DONE: the operation is abandoned; state goes to IDLE; no out_valid pulse is produced.
- Result: D must equal (A - B - bin) mod 2^width bit-exactly.

Test Plan:
- Reset then A=16'h1234, B=16'h0234, bin=0 accepted -> out_valid 2 cycles after accept; D=16'h1000, bout=0, ovf=0, zero=0.
- A=16'h0000, B=16'h0001, bin=0 -> D=16'hFFFF, bout=1, ovf=0; and A=16'h0100, B=16'h0001, bin=1 -> D=16'h00FE, bout=0 (borrow crosses chunk boundary).
- A=16'h8000, B=16'h0001, bin=0 -> D=16'h7FFF, ovf=1, bout=0; and A=16'h5555, B=16'h5555, bin=0 -> D=0, zero=1, bout=0.
- Back-pressure: out_ready low for 5 cycles after out_valid; toggle A, B and in_valid meanwhile -> D, flags and out_valid held, in_ready=0 throughout; the result leaves on the first out_ready edge.
- Assert rst during CALC -> next cycle out_valid=0 and D=0; in_ready=1 the cycle after rst drops; no stale result appears.
- 2000 random back-to-back operations with random in_valid/out_ready gaps -> every D, bout and ovf matches the behavioural model; each accepted op yields exactly one result, in order.
